// File: rtl/led_frame_sched_if.sv
// Handshake bundle between the frame scheduler, its requester, the FIFO fill controller and PHY.
// The scheduler takes the slave modport; the surrounding logic (or a bench) takes master.
interface led_frame_sched_if;
  logic        cfg_enable;
  logic        frame_req;
  logic        fill_en;
  logic        fill_start;
  logic        send_start_in;
  logic        phy_done;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        overrun;
  logic        err_timeout;

  modport master (
    output cfg_enable, frame_req, send_start_in, phy_done,
    input  fill_en, fill_start, busy, frame_cnt, overrun, err_timeout
  );

  modport slave (
    input  cfg_enable, frame_req, send_start_in, phy_done,
    output fill_en, fill_start, busy, frame_cnt, overrun, err_timeout
  );
endinterface

// File: rtl/led_frame_sched.sv
// Frame-level scheduler for the LED strip path: arms the fill controller, waits for PHY completion,
// enforces the latch gap and a minimum refresh period. Define LED_SCHED_TIMEOUT_EN for a watchdog.
module led_frame_sched #(
  parameter int unsigned LATCH_CYCLES   = 15000,
  parameter int unsigned REFRESH_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input logic              clk,
  input logic              rstn,
  led_frame_sched_if.slave bus
);

  localparam int unsigned LatchW  = $clog2(LATCH_CYCLES) + 1;
  localparam int unsigned PeriodW = $clog2(REFRESH_CYCLES) + 1;
  localparam logic [LatchW-1:0]  LatchLast = LatchW'(LATCH_CYCLES - 1);
  localparam logic [PeriodW-1:0] PeriodMax = PeriodW'(REFRESH_CYCLES);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StArm   = 3'd1;
  localparam logic [2:0] StStart = 3'd2;
  localparam logic [2:0] StFill  = 3'd3;
  localparam logic [2:0] StTx    = 3'd4;
  localparam logic [2:0] StLatch = 3'd5;

  logic [2:0]         state_q, state_d;
  logic               req_pend_q, req_pend_d;
  logic [PeriodW-1:0] period_q, period_d;
  logic [LatchW-1:0]  latch_q, latch_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               overrun_q, overrun_d;
  logic               period_ok;
  logic               go_arm;
  logic               wd_fire;

  assign period_ok = (period_q == PeriodMax);
  assign go_arm    = (state_q == StIdle) && bus.cfg_enable && req_pend_q && period_ok;

  // A request landing on the arming edge survives, so it is served by a later frame.
  assign req_pend_d = bus.frame_req | (req_pend_q & ~go_arm);
  assign overrun_d  = bus.frame_req & req_pend_q;

  always_comb begin
    period_d = period_q;
    if (go_arm) begin
      period_d = '0;
    end else if (!period_ok) begin
      period_d = period_q + PeriodW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    latch_d     = latch_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      StIdle:  if (go_arm) state_d = StArm;
      StArm:   state_d = StStart;
      StStart: state_d = StFill;
      StFill: begin
        if (bus.send_start_in) begin
          state_d = StTx;
        end else if (wd_fire) begin
          state_d = StLatch;
          latch_d = '0;
        end
      end
      StTx: begin
        if (bus.phy_done) begin
          state_d     = StLatch;
          latch_d     = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else if (wd_fire) begin
          state_d = StLatch;
          latch_d = '0;
        end
      end
      StLatch: begin
        if (latch_q == LatchLast) begin
          state_d = StIdle;
        end else begin
          latch_d = latch_q + LatchW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      req_pend_q  <= 1'b0;
      period_q    <= PeriodMax;
      latch_q     <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_pend_q  <= req_pend_d;
      period_q    <= period_d;
      latch_q     <= latch_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef LED_SCHED_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q;
  logic           timeout_hit;
  logic           in_wait;

  assign in_wait = (state_q == StFill) || (state_q == StTx);
  assign wd_fire = in_wait && (wd_q == WdLast);
  // Normal completion on the final watchdog cycle wins over the timeout.
  assign timeout_hit = wd_fire && ((state_q == StFill && !bus.send_start_in) ||
                                   (state_q == StTx && !bus.phy_done));

  always_comb begin
    wd_d = '0;
    if (in_wait && (state_d == state_q)) begin
      wd_d = wd_q + WdW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_q | timeout_hit;
    end
  end

  assign bus.err_timeout = err_q;
`else
  assign wd_fire         = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.fill_en    = (state_q == StArm);
  assign bus.fill_start = (state_q == StStart);
  assign bus.busy       = (state_q != StIdle);
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_led_frame_sched.sv
// Bench for led_frame_sched: directed table, hand-written corner sequences and random stimulus,
// all cross-checked every cycle against a timestamp-based behavioural model.
module tb_led_frame_sched;
  localparam int unsigned L = 8;
  localparam int unsigned R = 64;
  localparam int unsigned T = 100;
`ifdef LED_SCHED_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  led_frame_sched_if bus ();

  led_frame_sched #(
    .LATCH_CYCLES  (L),
    .REFRESH_CYCLES(R),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_fe   = 0;
  int n_ov   = 0;

  typedef enum {MIdle, MArm, MStart, MFill, MTx, MLatch} mph_t;
  mph_t        m_ph;
  bit          m_pend, m_over, m_err, m_armed;
  logic [15:0] m_cnt;
  int          m_last_arm, m_enter, m_left;

  typedef struct {
    int          cyc;
    bit          fr, ss, pd;
    bit          fe, fs, busy;
    logic [15:0] cnt;
  } row_t;
  row_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ph       = MIdle;
    m_pend     = 1'b0;
    m_over     = 1'b0;
    m_err      = 1'b0;
    m_armed    = 1'b0;
    m_cnt      = '0;
    m_last_arm = -1000;
    m_enter    = 0;
    m_left     = 0;
  endtask

  // Advance the model across one clock edge given this cycle's inputs.
  task automatic model_advance(input bit en, input bit fr, input bit ss, input bit pd);
    bit go;
    go     = (m_ph == MIdle) && en && m_pend && (!m_armed || (cyc - m_last_arm >= int'(R)));
    m_over = fr && m_pend;
    case (m_ph)
      MIdle: if (go) begin
        m_ph = MArm; m_last_arm = cyc + 1; m_armed = 1'b1;
      end
      MArm:   m_ph = MStart;
      MStart: begin m_ph = MFill; m_enter = cyc + 1; end
      MFill: begin
        if (ss) begin
          m_ph = MTx; m_enter = cyc + 1;
        end else if (TO && (cyc - m_enter == int'(T) - 1)) begin
          m_ph = MLatch; m_left = L; m_err = 1'b1;
        end
      end
      MTx: begin
        if (pd) begin
          m_ph = MLatch; m_left = L; m_cnt = m_cnt + 16'd1;
        end else if (TO && (cyc - m_enter == int'(T) - 1)) begin
          m_ph = MLatch; m_left = L; m_err = 1'b1;
        end
      end
      MLatch: begin
        m_left--;
        if (m_left == 0) m_ph = MIdle;
      end
      default: m_ph = MIdle;
    endcase
    m_pend = fr ? 1'b1 : (go ? 1'b0 : m_pend);
  endtask

  task automatic step(input bit en, input bit fr, input bit ss, input bit pd);
    bus.cfg_enable    = en;
    bus.frame_req     = fr;
    bus.send_start_in = ss;
    bus.phy_done      = pd;
    chk("fill_en", bus.fill_en, cyc == m_last_arm);
    chk("fill_start", bus.fill_start, cyc == m_last_arm + 1);
    chk("busy", bus.busy, m_ph != MIdle);
    chk("frame_cnt", bus.frame_cnt, m_cnt);
    chk("overrun", bus.overrun, m_over);
    chk("err_timeout", bus.err_timeout, m_err);
    n_fe += int'(bus.fill_en);
    n_ov += int'(bus.overrun);
    model_advance(en, fr, ss, pd);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n, input bit en, input bit fr, input bit ss, input bit pd);
    for (int i = 0; i < n; i++) step(en, fr, ss, pd);
  endtask

  task automatic wait_fe(input string name, input int budget);
    for (int i = 0; i < budget && bus.fill_en !== 1'b1; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk(name, bus.fill_en, 1);
  endtask

  task automatic do_reset();
    rstn              = 1'b0;
    bus.cfg_enable    = 1'b0;
    bus.frame_req     = 1'b0;
    bus.send_start_in = 1'b0;
    bus.phy_done      = 1'b0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    cyc = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fe0, ov0;
    bit en_r;
    // {cycle, frame_req, send_start_in, phy_done, exp fill_en, fill_start, busy, frame_cnt}
    tbl = '{
      '{0,  0, 0, 0, 0, 0, 0, 16'd0}, '{10, 1, 0, 0, 0, 0, 0, 16'd0},
      '{11, 0, 0, 0, 0, 0, 0, 16'd0}, '{12, 0, 0, 0, 1, 0, 1, 16'd0},
      '{13, 0, 0, 0, 0, 1, 1, 16'd0}, '{14, 0, 0, 0, 0, 0, 1, 16'd0},
      '{20, 0, 1, 0, 0, 0, 1, 16'd0}, '{30, 0, 0, 1, 0, 0, 1, 16'd0},
      '{31, 0, 0, 0, 0, 0, 1, 16'd1}, '{38, 0, 0, 0, 0, 0, 1, 16'd1},
      '{39, 0, 0, 0, 0, 0, 0, 16'd1}, '{40, 1, 0, 0, 0, 0, 0, 16'd1},
      '{76, 0, 0, 0, 0, 0, 0, 16'd1}, '{77, 0, 0, 0, 1, 0, 1, 16'd1},
      '{78, 0, 0, 0, 0, 1, 1, 16'd1}
    };

    do_reset();
    chk("reset_overrun", bus.overrun, 0);
    chk("reset_err", bus.err_timeout, 0);

    // Basic frame followed by a rate-limited second arm.
    for (int c = 0; c <= 80; c++) begin
      bit fr, ss, pd;
      fr = 1'b0; ss = 1'b0; pd = 1'b0;
      foreach (tbl[i]) begin
        if (tbl[i].cyc == c) begin
          fr = tbl[i].fr; ss = tbl[i].ss; pd = tbl[i].pd;
          chk("tbl_fill_en", bus.fill_en, tbl[i].fe);
          chk("tbl_fill_start", bus.fill_start, tbl[i].fs);
          chk("tbl_busy", bus.busy, tbl[i].busy);
          chk("tbl_frame_cnt", bus.frame_cnt, tbl[i].cnt);
        end
      end
      step(1'b1, fr, ss, pd);
    end

    // Coalescing: three requests during TX -> two overruns, one further frame.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    ov0 = n_ov;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("coalesce_cnt2", bus.frame_cnt, 2);
    fe0 = n_fe;
    run(300, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("coalesce_overruns", n_ov - ov0, 2);
    chk("coalesce_one_frame", n_fe - fe0, 1);
    chk("coalesce_cnt3", bus.frame_cnt, 3);

    // Disable during TX: frame completes, no new arm until re-enabled.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    wait_fe("dis_arm", 200);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    fe0 = n_fe;
    run(150, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dis_no_arm", n_fe - fe0, 0);
    chk("dis_idle", bus.busy, 0);
    chk("dis_cnt4", bus.frame_cnt, 4);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    wait_fe("reen_arm", 5);
    run(20, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("reen_cnt5", bus.frame_cnt, 5);

    // Reset during FILL.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    wait_fe("rst_arm", 200);
    run(3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_pre_busy", bus.busy, 1);
    rstn = 1'b0;
    #1;
    chk("rst_fill_en", bus.fill_en, 0);
    chk("rst_fill_start", bus.fill_start, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cnt", bus.frame_cnt, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_err", bus.err_timeout, 0);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    fe0 = n_fe;
    run(100, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_no_arm", n_fe - fe0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    wait_fe("rst_new_arm", 5);

    // Missing send_start_in: watchdog fires only when enabled.
    run(2, 1'b1, 1'b0, 1'b0, 1'b0);
    run(150, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wd_err", bus.err_timeout, TO);
    chk("wd_busy", bus.busy, !TO);
    chk("wd_cnt", bus.frame_cnt, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    run(20, 1'b1, 1'b0, 1'b0, 1'b1);

    // Random traffic against the model.
    en_r = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) en_r = !en_r;
      step(en_r, $urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
